// File: rtl/rgmii_rx_deframer.sv
// RGMII 10/100 (nibble mode) receive deframer: strips preamble/SFD, streams frame bytes
// with first/last markers and reports FCS, length and nibble-alignment status per frame.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | line quiet, waiting for the first preamble nibble
// PREAMBLE   | counting 0x5 nibbles, waiting for the 0xD SFD
// DATA_LO    | expecting the low nibble of the next byte (or end of frame)
// DATA_HI    | low nibble held, expecting the high nibble
// WAIT_IDLE  | malformed preamble, discarding until RX_DV drops
module rgmii_rx_deframer #(
    parameter int MIN_PRE = 2,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        ETH_RXCLK,
    input  logic        RSTN,
    input  logic [3:0]  ETH_RX,
    input  logic        ETH_RXCTRL,
    output logic [7:0]  RX_DATA,
    output logic        RX_VALID,
    output logic        RX_FIRST,
    output logic        RX_LAST,
    output logic        FRAME_DONE,
    output logic        FRAME_GOOD,
    output logic        CRC_ERR,
    output logic        LEN_ERR,
    output logic        ALIGN_ERR,
    output logic [15:0] FRAME_LEN
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PREAMBLE  = 3'd1;
    localparam logic [2:0] DATA_LO   = 3'd2;
    localparam logic [2:0] DATA_HI   = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;

    localparam logic [3:0]  MIN_PRE_W   = 4'(MIN_PRE);
    localparam logic [15:0] MIN_LEN_W   = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_W   = 16'(MAX_LEN);
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    logic [2:0]  state;
    logic [3:0]  pre_cnt;
    logic [3:0]  low_nib;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [15:0] len;
    logic [15:0] len_next;
    logic [7:0]  hold;
    logic [7:0]  rx_byte;
    logic        hold_valid;
    logic        first_pend;
    logic        keep_byte;
    logic        frame_end;
    logic        align_bad;
    logic        crc_bad;
    logic        len_bad;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    always_comb begin
        rx_byte   = {ETH_RX, low_nib};
        crc_next  = crc32_byte(crc, rx_byte);
        len_next  = (len == 16'hFFFF) ? len : len + 16'd1;
        // bytes past MAX_LEN are counted but never enter the hold register
        keep_byte = (len_next <= MAX_LEN_W);
        frame_end = !ETH_RXCTRL && ((state == DATA_LO) || (state == DATA_HI));
        align_bad = (state == DATA_HI);
        crc_bad   = (crc != CRC_RESIDUE);
        len_bad   = (len < MIN_LEN_W) || (len > MAX_LEN_W);
    end

    always_ff @(posedge ETH_RXCLK or negedge RSTN) begin
        if (!RSTN) begin
            state      <= IDLE;
            pre_cnt    <= '0;
            low_nib    <= '0;
            crc        <= '1;
            len        <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            first_pend <= 1'b0;
            RX_DATA    <= '0;
            RX_VALID   <= 1'b0;
            RX_FIRST   <= 1'b0;
            RX_LAST    <= 1'b0;
            FRAME_DONE <= 1'b0;
            FRAME_GOOD <= 1'b0;
            CRC_ERR    <= 1'b0;
            LEN_ERR    <= 1'b0;
            ALIGN_ERR  <= 1'b0;
            FRAME_LEN  <= '0;
        end else begin
            RX_VALID   <= 1'b0;
            RX_FIRST   <= 1'b0;
            RX_LAST    <= 1'b0;
            FRAME_DONE <= 1'b0;
            FRAME_GOOD <= 1'b0;
            CRC_ERR    <= 1'b0;
            LEN_ERR    <= 1'b0;
            ALIGN_ERR  <= 1'b0;
            FRAME_LEN  <= '0;

            case (state)
                IDLE: begin
                    if (ETH_RXCTRL) begin
                        if (ETH_RX == 4'h5) begin
                            state   <= PREAMBLE;
                            pre_cnt <= 4'd1;
                        end else begin
                            state <= WAIT_IDLE;
                        end
                    end
                end
                PREAMBLE: begin
                    if (!ETH_RXCTRL) begin
                        state <= IDLE;
                    end else if (ETH_RX == 4'h5) begin
                        if (pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
                    end else if ((ETH_RX == 4'hD) && (pre_cnt >= MIN_PRE_W)) begin
                        state      <= DATA_LO;
                        crc        <= '1;
                        len        <= '0;
                        hold_valid <= 1'b0;
                        first_pend <= 1'b1;
                    end else begin
                        state <= WAIT_IDLE;
                    end
                end
                DATA_LO: begin
                    if (ETH_RXCTRL) begin
                        low_nib <= ETH_RX;
                        state   <= DATA_HI;
                    end
                end
                DATA_HI: begin
                    if (ETH_RXCTRL) begin
                        crc   <= crc_next;
                        len   <= len_next;
                        state <= DATA_LO;
                        if (keep_byte) begin
                            hold       <= rx_byte;
                            hold_valid <= 1'b1;
                            // a newer byte exists, so the held one is not the last
                            if (hold_valid) begin
                                RX_VALID   <= 1'b1;
                                RX_DATA    <= hold;
                                RX_FIRST   <= first_pend;
                                first_pend <= 1'b0;
                            end
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (!ETH_RXCTRL) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (frame_end) begin
                state      <= IDLE;
                FRAME_DONE <= 1'b1;
                CRC_ERR    <= crc_bad;
                LEN_ERR    <= len_bad;
                ALIGN_ERR  <= align_bad;
                FRAME_GOOD <= !(crc_bad || len_bad || align_bad);
                FRAME_LEN  <= len;
                if (hold_valid) begin
                    RX_VALID <= 1'b1;
                    RX_DATA  <= hold;
                    RX_FIRST <= first_pend;
                    RX_LAST  <= 1'b1;
                end
                hold_valid <= 1'b0;
                first_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rgmii_rx_deframer.sv
// Self-checking bench for rgmii_rx_deframer: random frames are compared against a
// frame-level model (byte list, FCS recomputed from the payload, length rules).
module tb_rgmii_rx_deframer;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] data;
        logic       first;
        logic       last;
        int         cyc;
    } rx_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  nib = 4'h0;
    logic        ctrl = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_first, rx_last;
    logic        frame_done, frame_good, crc_err, len_err, align_err;
    logic [15:0] frame_len;

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   end_cyc = 0;
    int   hi_cyc[$];
    rx_t  rx_q[$];
    logic [19:0] st_q[$];

    rgmii_rx_deframer dut (
        .ETH_RXCLK  (clk),
        .RSTN       (rstn),
        .ETH_RX     (nib),
        .ETH_RXCTRL (ctrl),
        .RX_DATA    (rx_data),
        .RX_VALID   (rx_valid),
        .RX_FIRST   (rx_first),
        .RX_LAST    (rx_last),
        .FRAME_DONE (frame_done),
        .FRAME_GOOD (frame_good),
        .CRC_ERR    (crc_err),
        .LEN_ERR    (len_err),
        .ALIGN_ERR  (align_err),
        .FRAME_LEN  (frame_len)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back('{rx_data, rx_first, rx_last, cyc});
        if (frame_done) st_q.push_back({frame_good, crc_err, len_err, align_err, frame_len});
    end

    function automatic logic [31:0] crc32(bq_t d, int cnt);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < cnt; i++) begin
            c = c ^ {24'h0, d[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t make_frame(int n);
        bq_t f;
        logic [31:0] c;
        for (int i = 0; i < n - 4; i++) f.push_back(8'($urandom));
        c = crc32(f, n - 4);
        for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
        return f;
    endfunction

    // frame-level expectation: {good, crc_err, len_err, align_err, len}
    function automatic logic [19:0] model_status(bq_t f, logic odd);
        int n = f.size();
        logic crc_e, len_e;
        logic [31:0] fcs;
        if (n < 4) crc_e = 1'b1;
        else begin
            fcs   = {f[n-1], f[n-2], f[n-3], f[n-4]};
            crc_e = (crc32(f, n - 4) != fcs);
        end
        len_e = (n < 64) || (n > 1518);
        return {!(crc_e || len_e || odd), crc_e, len_e, odd, 16'((n > 65535) ? 65535 : n)};
    endfunction

    function automatic int exp_count(int n);
        return (n > 1518) ? 1518 : n;
    endfunction

    function automatic int stream_errs(bq_t f, int off);
        int m = exp_count(f.size());
        int e = 0;
        for (int i = 0; i < m; i++) begin
            if (off + i >= rx_q.size()) e++;
            else if (rx_q[off+i].data !== f[i] || rx_q[off+i].first !== (i == 0) ||
                     rx_q[off+i].last !== (i == m - 1)) e++;
        end
        return e;
    endfunction

    task automatic send_nib(input logic c, input logic [3:0] n);
        @(negedge clk);
        ctrl = c;
        nib  = n;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bq_t f, input int npre, input logic odd);
        hi_cyc.delete();
        repeat (npre) send_nib(1'b1, 4'h5);
        send_nib(1'b1, 4'hD);
        foreach (f[i]) begin
            send_nib(1'b1, f[i][3:0]);
            send_nib(1'b1, f[i][7:4]);
            hi_cyc.push_back(cyc + 1);
        end
        if (odd) send_nib(1'b1, 4'($urandom));
        send_nib(1'b0, 4'h0);
        end_cyc = cyc + 1;
    endtask

    task automatic clear_q;
        rx_q.delete();
        st_q.delete();
    endtask

    bq_t good_f;

    task automatic test_reset;
        rstn = 1'b0;
        ctrl = 1'b0;
        idle(3);
        n_checks++;
        if ({rx_data, rx_valid, rx_first, rx_last, frame_done, frame_good, crc_err, len_err,
             align_err, frame_len} !== 32'h0)
            $display("FAIL reset_outputs: got %h required 0", {rx_data, rx_valid, rx_first,
                     rx_last, frame_done, frame_good, crc_err, len_err, align_err, frame_len});
        else n_pass++;
        rstn = 1'b1;
        clear_q();
        idle(4);
        n_checks++;
        if (rx_q.size() + st_q.size() !== 0)
            $display("FAIL reset_quiet: got %0d strobes required 0", rx_q.size() + st_q.size());
        else n_pass++;
    endtask

    task automatic test_good_frame;
        int late = 0;
        logic [19:0] exp_st;
        good_f = make_frame(64);
        exp_st = model_status(good_f, 1'b0);
        clear_q();
        send_frame(good_f, 14, 1'b0);
        idle(3);
        n_checks++;
        if (stream_errs(good_f, 0) !== 0 || rx_q.size() !== 64)
            $display("FAIL good_stream: %0d byte errors, %0d bytes seen, required 64",
                     stream_errs(good_f, 0), rx_q.size());
        else n_pass++;
        n_checks++;
        if (st_q.size() !== 1) $display("FAIL good_done_count: got %0d required 1", st_q.size());
        else n_pass++;
        n_checks++;
        if (st_q.size() == 0 || st_q[0] !== exp_st || exp_st[19] !== 1'b1)
            $display("FAIL good_status: got %h required %h", (st_q.size() > 0) ? st_q[0] : 20'hx, exp_st);
        else n_pass++;
        for (int i = 0; i < rx_q.size() && i < hi_cyc.size(); i++) begin
            if (rx_q[i].cyc != ((i == hi_cyc.size() - 1) ? end_cyc : hi_cyc[i] + 2)) late++;
        end
        n_checks++;
        if (late !== 0) $display("FAIL good_latency: %0d bytes off-time, required 0", late);
        else n_pass++;
    endtask

    task automatic test_crc_error;
        bq_t f = good_f;
        logic [19:0] exp_st;
        f[20][0] = !f[20][0];
        exp_st = model_status(f, 1'b0);
        clear_q();
        send_frame(f, 14, 1'b0);
        idle(3);
        n_checks++;
        if (stream_errs(f, 0) !== 0 || rx_q.size() !== 64)
            $display("FAIL crc_stream: %0d byte errors, %0d bytes seen", stream_errs(f, 0), rx_q.size());
        else n_pass++;
        n_checks++;
        if (st_q.size() !== 1 || st_q[0] !== exp_st || exp_st[18] !== 1'b1)
            $display("FAIL crc_status: got %h required %h", (st_q.size() > 0) ? st_q[0] : 20'hx, exp_st);
        else n_pass++;
    endtask

    task automatic test_align_error;
        bq_t f = make_frame(64);
        logic [19:0] exp_st = model_status(f, 1'b1);
        clear_q();
        send_frame(f, 7, 1'b1);
        idle(3);
        n_checks++;
        if (stream_errs(f, 0) !== 0 || rx_q.size() !== 64)
            $display("FAIL align_stream: %0d byte errors, %0d bytes seen", stream_errs(f, 0), rx_q.size());
        else n_pass++;
        n_checks++;
        if (st_q.size() !== 1 || st_q[0] !== exp_st)
            $display("FAIL align_status: got %h required %h", (st_q.size() > 0) ? st_q[0] : 20'hx, exp_st);
        else n_pass++;
    endtask

    task automatic test_short_frame;
        bq_t f = make_frame(40);
        logic [19:0] exp_st = model_status(f, 1'b0);
        clear_q();
        send_frame(f, 2, 1'b0);
        idle(3);
        n_checks++;
        if (stream_errs(f, 0) !== 0 || rx_q.size() !== 40)
            $display("FAIL short_stream: %0d byte errors, %0d bytes seen", stream_errs(f, 0), rx_q.size());
        else n_pass++;
        n_checks++;
        if (st_q.size() !== 1 || st_q[0] !== exp_st)
            $display("FAIL short_status: got %h required %h", (st_q.size() > 0) ? st_q[0] : 20'hx, exp_st);
        else n_pass++;
    endtask

    task automatic test_empty_frame;
        bq_t f;
        logic [19:0] exp_st = model_status(f, 1'b0);
        clear_q();
        send_frame(f, 5, 1'b0);
        idle(3);
        n_checks++;
        if (rx_q.size() !== 0) $display("FAIL empty_stream: got %0d bytes required 0", rx_q.size());
        else n_pass++;
        n_checks++;
        if (st_q.size() !== 1 || st_q[0] !== exp_st)
            $display("FAIL empty_status: got %h required %h", (st_q.size() > 0) ? st_q[0] : 20'hx, exp_st);
        else n_pass++;
    endtask

    task automatic test_bad_preamble;
        bq_t f = make_frame(64);
        logic [19:0] exp_st = model_status(f, 1'b0);
        clear_q();
        repeat (6) send_nib(1'b1, 4'h5);
        send_nib(1'b1, 4'h3);
        send_nib(1'b1, 4'h5);
        send_nib(1'b1, 4'hD);
        send_nib(1'b1, 4'h7);
        send_nib(1'b0, 4'h0);
        send_nib(1'b1, 4'h5);
        send_nib(1'b1, 4'hD);
        send_nib(1'b1, 4'h1);
        send_nib(1'b0, 4'h0);
        idle(3);
        n_checks++;
        if (rx_q.size() + st_q.size() !== 0)
            $display("FAIL badpre_quiet: got %0d strobes required 0", rx_q.size() + st_q.size());
        else n_pass++;
        send_nib(1'b0, 4'h0);
        send_frame(f, 3, 1'b0);
        idle(3);
        n_checks++;
        if (stream_errs(f, 0) !== 0 || rx_q.size() !== 64)
            $display("FAIL badpre_next_stream: %0d byte errors, %0d bytes seen", stream_errs(f, 0), rx_q.size());
        else n_pass++;
        n_checks++;
        if (st_q.size() !== 1 || st_q[0] !== exp_st)
            $display("FAIL badpre_next_status: got %h required %h", (st_q.size() > 0) ? st_q[0] : 20'hx, exp_st);
        else n_pass++;
    endtask

    task automatic test_reset_midframe;
        bq_t f = make_frame(64);
        bq_t g = make_frame(80);
        logic [19:0] exp_st = model_status(g, 1'b0);
        clear_q();
        repeat (8) send_nib(1'b1, 4'h5);
        send_nib(1'b1, 4'hD);
        for (int i = 0; i < 30; i++) begin
            send_nib(1'b1, f[i][3:0]);
            send_nib(1'b1, f[i][7:4]);
        end
        #2 rstn = 1'b0;
        ctrl = 1'b0;
        #1;
        n_checks++;
        if ({rx_data, rx_valid, rx_first, rx_last, frame_done, frame_good, crc_err, len_err,
             align_err, frame_len} !== 32'h0)
            $display("FAIL midreset_outputs: got %h required 0", {rx_data, rx_valid, rx_first,
                     rx_last, frame_done, frame_good, crc_err, len_err, align_err, frame_len});
        else n_pass++;
        idle(2);
        rstn = 1'b1;
        idle(3);
        n_checks++;
        if (st_q.size() !== 0) $display("FAIL midreset_done: got %0d required 0", st_q.size());
        else n_pass++;
        clear_q();
        send_frame(g, 10, 1'b0);
        idle(3);
        n_checks++;
        if (stream_errs(g, 0) !== 0 || rx_q.size() !== 80)
            $display("FAIL midreset_next_stream: %0d byte errors, %0d bytes seen", stream_errs(g, 0), rx_q.size());
        else n_pass++;
        n_checks++;
        if (st_q.size() !== 1 || st_q[0] !== exp_st)
            $display("FAIL midreset_next_status: got %h required %h", (st_q.size() > 0) ? st_q[0] : 20'hx, exp_st);
        else n_pass++;
    endtask

    task automatic test_oversize;
        bq_t f = make_frame(1520);
        logic [19:0] exp_st = model_status(f, 1'b0);
        clear_q();
        send_frame(f, 9, 1'b0);
        idle(3);
        n_checks++;
        if (stream_errs(f, 0) !== 0 || rx_q.size() !== 1518)
            $display("FAIL oversize_stream: %0d byte errors, %0d bytes seen, required 1518",
                     stream_errs(f, 0), rx_q.size());
        else n_pass++;
        n_checks++;
        if (st_q.size() !== 1 || st_q[0] !== exp_st)
            $display("FAIL oversize_status: got %h required %h", (st_q.size() > 0) ? st_q[0] : 20'hx, exp_st);
        else n_pass++;
    endtask

    task automatic test_random;
        for (int k = 0; k < 8; k++) begin
            bq_t f = make_frame(int'($urandom_range(20, 200)));
            logic odd = ($urandom_range(0, 3) == 0);
            int npre = int'($urandom_range(2, 20));
            logic [19:0] exp_st;
            if ($urandom_range(0, 2) == 0) begin
                int j = int'($urandom_range(0, f.size() - 1));
                int b = int'($urandom_range(0, 7));
                f[j][b] = !f[j][b];
            end
            exp_st = model_status(f, odd);
            clear_q();
            send_frame(f, npre, odd);
            idle(3);
            n_checks++;
            if (stream_errs(f, 0) !== 0 || rx_q.size() !== exp_count(f.size()))
                $display("FAIL random%0d_stream: %0d byte errors, %0d bytes seen, required %0d",
                         k, stream_errs(f, 0), rx_q.size(), exp_count(f.size()));
            else n_pass++;
            n_checks++;
            if (st_q.size() !== 1 || st_q[0] !== exp_st)
                $display("FAIL random%0d_status: got %h required %h", k,
                         (st_q.size() > 0) ? st_q[0] : 20'hx, exp_st);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        bq_t f1 = make_frame(64);
        bq_t f2 = make_frame(70);
        logic [19:0] e1 = model_status(f1, 1'b0);
        logic [19:0] e2 = model_status(f2, 1'b0);
        clear_q();
        send_frame(f1, 2, 1'b0);
        send_frame(f2, 2, 1'b0);
        idle(3);
        n_checks++;
        if (stream_errs(f1, 0) + stream_errs(f2, 64) !== 0 || rx_q.size() !== 134)
            $display("FAIL b2b_stream: %0d byte errors, %0d bytes seen, required 134",
                     stream_errs(f1, 0) + stream_errs(f2, 64), rx_q.size());
        else n_pass++;
        n_checks++;
        if (st_q.size() !== 2 || st_q[0] !== e1 || st_q[1] !== e2)
            $display("FAIL b2b_status: got %0d strobes, first %h, required %h then %h",
                     st_q.size(), (st_q.size() > 0) ? st_q[0] : 20'hx, e1, e2);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_crc_error();
        test_align_error();
        test_short_frame();
        test_empty_frame();
        test_bad_preamble();
        test_reset_midframe();
        test_oversize();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/rgmii_rx_deframer.md
Name: rgmii_rx_deframer

Overview:
- Receive-side Ethernet deframer for the RGMII link, running in 10/100 nibble mode: one nibble per rising edge of ETH_RXCLK, with ETH_RXCTRL acting as RX_DV.
- Sits in top behind the ETH_RX / ETH_RX_CTRL / ETH_RX_CLK pins and consumes what tx_phy drives.
- Strips preamble/SFD, assembles bytes low-nibble first, streams them out with first/last markers, and checks FCS (CRC-32), length and nibble alignment per frame.

Parameters:
MIN_PRE, 2, minimum count of 0x5 preamble nibbles required before SFD.
MIN_LEN, 64, minimum frame length in bytes (DA through FCS).
MAX_LEN, 1518, maximum frame length in bytes (DA through FCS).

Ports:
ETH_RXCLK  in  1  receive clock; all logic on rising edge
RSTN  in  1  asynchronous active-low reset
ETH_RX  in  4  receive nibble
ETH_RXCTRL  in  1  data valid
RX_DATA  out  8  frame byte (DA through FCS)
RX_VALID  out  1  RX_DATA valid, one-cycle strobe
RX_FIRST  out  1  marks the first byte of a frame; qualified by RX_VALID
RX_LAST  out  1  marks the last byte of a frame; qualified by RX_VALID
FRAME_DONE  out  1  one-cycle end-of-frame status strobe
FRAME_GOOD  out  1  frame had no errors; qualified by FRAME_DONE
CRC_ERR  out  1  FCS residue mismatch; qualified by FRAME_DONE
LEN_ERR  out  1  length below MIN_LEN or above MAX_LEN; qualified by FRAME_DONE
ALIGN_ERR  out  1  odd nibble count; qualified by FRAME_DONE
FRAME_LEN  out  16  byte count of the frame, saturating at 0xFFFF; qualified by FRAME_DONE

Behaviour:
- Reset (RSTN low, asynchronous):
  - all outputs 0; state IDLE; CRC register 0xFFFFFFFF; counters 0.
  - Reset mid-frame discards the frame; no FRAME_DONE is produced.
- States: IDLE, PREAMBLE, DATA_LO, DATA_HI, WAIT_IDLE.
- IDLE:
  - ETH_RXCTRL=1 and ETH_RX=0x5 -> PREAMBLE, preamble count=1.
  - ETH_RXCTRL=1 with any other nibble -> WAIT_IDLE.
- PREAMBLE:
  - ETH_RXCTRL=0 -> IDLE silently.
  - 0x5 -> stay, count saturates at 15.
  - 0xD with count>=MIN_PRE -> DATA_LO; CRC register reset to 0xFFFFFFFF; length counter 0; first flag set.
  - Any other nibble, or 0xD too early -> WAIT_IDLE.
- DATA_LO:
  - ETH_RXCTRL=1 -> latch nibble as low half -> DATA_HI.
  - ETH_RXCTRL=0 -> end of frame (see below) -> IDLE.
- DATA_HI:
  - ETH_RXCTRL=1 -> byte={ETH_RX, low}; update CRC with byte (reflected CRC-32, poly 0xEDB88320, LSB first); length+1 -> DATA_LO.
  - ETH_RXCTRL=0 -> end of frame with ALIGN_ERR=1 -> IDLE.
- WAIT_IDLE: no output; leave to IDLE on ETH_RXCTRL=0. No FRAME_DONE is produced for frames rejected before SFD.
- One-byte holding register (required because the last byte is unknown until ETH_RXCTRL drops):
  - Each completed byte goes into the hold register.
  - The previously held byte is emitted (RX_VALID=1) on the same edge the new byte completes.
  - RX_FIRST accompanies the first emitted byte.
- End of frame:
  - On the edge that samples ETH_RXCTRL=0, the held byte is emitted with RX_LAST=1.
  - The same cycle carries FRAME_DONE=1 and all status outputs.
  - A frame with zero completed bytes produces FRAME_DONE with LEN_ERR=1 and no RX_VALID.
- Status rules:
  - CRC_ERR = (CRC register != 0xDEBB20E3) after all bytes including FCS.
  - LEN_ERR = len<MIN_LEN or len>MAX_LEN.
  - FRAME_GOOD = none of CRC_ERR, LEN_ERR, ALIGN_ERR.
- Oversize frames: bytes are not emitted beyond MAX_LEN; a frame whose length passes MAX_LEN still ends with RX_LAST on the last emitted byte, at FRAME_DONE, with LEN_ERR=1.
- Latency: byte N appears 2 nibble-cycles after its high nibble is sampled (or on the end edge, for the last byte).
- No backpressure: the consumer must accept one byte every 2 cycles.
- Back-to-back frames with a single ETH_RXCTRL=0 cycle between them are supported.

Test Plan:
- 14×0x5, 0xD, then a 64-byte frame with correct FCS -> 64 RX_VALID strobes; RX_FIRST on byte 0; RX_LAST on byte 63; FRAME_DONE with FRAME_GOOD=1 and FRAME_LEN=64.
- Same frame with bit 0 of byte 20 flipped -> 64 bytes out, CRC_ERR=1, FRAME_GOOD=0.
- 64-byte frame plus one extra nibble before ETH_RXCTRL drops -> ALIGN_ERR=1 and FRAME_LEN=64.
- 40-byte frame with valid FCS -> LEN_ERR=1, CRC_ERR=0, FRAME_LEN=40.
- Preamble of 0x5s then 0x3 -> no RX_VALID and no FRAME_DONE; the next valid frame, after one idle cycle, is received with FRAME_GOOD=1.
- RSTN pulsed low after 30 bytes -> outputs go to 0 immediately, no FRAME_DONE; the following frame is received good.
